// File: rtl/gnn_seq_layer_if.sv
// Request/result bundle for gnn_seq_layer: start plus captured operands in, busy/done/results out.
interface gnn_seq_layer_if #(
   parameter int N_NODES = 4,
   parameter int F_IN    = 4,
   parameter int F_OUT   = 2,
   parameter int XW      = 5,
   parameter int WW      = 5,
   parameter int OW      = 17
);
   logic                            start;
   logic [N_NODES*F_IN*XW-1:0]      x_in;
   logic [F_IN*F_OUT*WW-1:0]        w_in;
   logic [N_NODES*N_NODES-1:0]      adj_in;
   logic                            busy;
   logic                            done;
   logic [N_NODES*F_OUT*OW-1:0]     out_data;

   modport master (output start, x_in, w_in, adj_in, input busy, done, out_data);
   modport slave  (input start, x_in, w_in, adj_in, output busy, done, out_data);
endinterface

// File: rtl/gnn_seq_layer.sv
// Time-multiplexed GNN layer: per-node adjacency aggregation, then one shared MAC applying F_IN x F_OUT weights.
// Define GNN_RELU_EN to clamp negative results to zero before they reach out_data.
module gnn_seq_layer #(
   parameter int N_NODES = 4,
   parameter int F_IN    = 4,
   parameter int F_OUT   = 2,
   parameter int XW      = 5,
   parameter int WW      = 5,
   parameter int OW      = 17
) (
   input  logic            clk,
   input  logic            rst_n,
   gnn_seq_layer_if.slave  bus
);
   localparam int AW   = XW + $clog2(N_NODES);
   localparam int ACCW = AW + WW + $clog2(F_IN);
   localparam int PW   = AW + WW;
   localparam int NW   = (N_NODES > 1) ? $clog2(N_NODES) : 1;
   localparam int IW   = (F_IN > 1) ? $clog2(F_IN) : 1;
   localparam int OCW  = (F_OUT > 1) ? $clog2(F_OUT) : 1;
   localparam int NS   = N_NODES * F_OUT;
   localparam int SW   = (NS > 1) ? $clog2(NS) : 1;

   if (OW < ACCW) begin : g_ow_check
      $error("gnn_seq_layer: OW must be >= ACCW");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AGGR = 2'd1,
      S_MAC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_state_next;
   logic signed [XW-1:0]       r_x    [N_NODES][F_IN];
   logic signed [WW-1:0]       r_w    [F_OUT][F_IN];
   logic [N_NODES-1:0]         r_adj  [N_NODES];
   logic signed [AW-1:0]       r_aggr [N_NODES][F_IN];
   logic signed [OW-1:0]       r_out  [NS];
   logic [NW-1:0]              r_n;
   logic [OCW-1:0]             r_o;
   logic [IW-1:0]              r_i;
   logic [SW-1:0]              r_slot;
   logic                       r_mac_end;
   logic signed [PW-1:0]       r_prod;
   logic                       r_pv;
   logic                       r_pfirst;
   logic                       r_plast;
   logic [SW-1:0]              r_pslot;
   logic signed [ACCW-1:0]     r_acc;
   logic                       r_busy;
   logic                       r_done;

   logic signed [AW-1:0]       w_aggr_row [F_IN];
   logic signed [PW-1:0]       w_prod;
   logic signed [ACCW-1:0]     w_acc_sum;
   logic signed [OW-1:0]       w_res;
   logic                       w_issue;
   logic                       w_last_n;
   logic                       w_last_o;
   logic                       w_last_i;

   assign w_last_n = (r_n == NW'(N_NODES - 1));
   assign w_last_o = (r_o == OCW'(F_OUT - 1));
   assign w_last_i = (r_i == IW'(F_IN - 1));
   assign w_issue  = (r_state == S_MAC) && !r_mac_end;

   // Products are registered, so the last (n,o) accumulates one cycle after its final issue.
   assign w_prod    = PW'(r_aggr[r_n][r_i]) * PW'(r_w[r_o][r_i]);
   assign w_acc_sum = (r_pfirst ? {ACCW{1'b0}} : r_acc) + ACCW'(r_prod);

   // Activation applied to each finished accumulator before write-back.
   always_comb begin
`ifdef GNN_RELU_EN
      if (w_acc_sum[ACCW-1]) begin
         w_res = {OW{1'b0}};
      end else begin
         w_res = OW'(w_acc_sum);
      end
`else
      w_res = OW'(w_acc_sum);
`endif
   end

   // Sum of neighbour features for the node currently addressed by r_n.
   always_comb begin
      for (int f = 0; f < F_IN; f++) begin
         w_aggr_row[f] = {AW{1'b0}};
      end
      for (int m = 0; m < N_NODES; m++) begin
         for (int f = 0; f < F_IN; f++) begin
            if (r_adj[r_n][m]) begin
               w_aggr_row[f] = w_aggr_row[f] + AW'(r_x[m][f]);
            end else begin
               w_aggr_row[f] = w_aggr_row[f];
            end
         end
      end
   end

   // Next-state logic for IDLE -> AGGR -> MAC -> DONE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_next = S_AGGR;
            else           w_state_next = S_IDLE;
         end
         S_AGGR: begin
            if (w_last_n) w_state_next = S_MAC;
            else          w_state_next = S_AGGR;
         end
         S_MAC: begin
            if (r_mac_end) w_state_next = S_DONE;
            else           w_state_next = S_MAC;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register, operand capture, aggregation, MAC datapath and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_n       <= '0;
         r_o       <= '0;
         r_i       <= '0;
         r_slot    <= '0;
         r_mac_end <= 1'b0;
         r_prod    <= '0;
         r_pv      <= 1'b0;
         r_pfirst  <= 1'b0;
         r_plast   <= 1'b0;
         r_pslot   <= '0;
         r_acc     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         for (int n = 0; n < N_NODES; n++) begin
            r_adj[n] <= '0;
            for (int f = 0; f < F_IN; f++) begin
               r_x[n][f]    <= '0;
               r_aggr[n][f] <= '0;
            end
         end
         for (int o = 0; o < F_OUT; o++) begin
            for (int i = 0; i < F_IN; i++) begin
               r_w[o][i] <= '0;
            end
         end
         for (int s = 0; s < NS; s++) begin
            r_out[s] <= '0;
         end
      end else begin
         r_state <= w_state_next;
         r_done  <= (w_state_next == S_DONE);
         r_pv    <= w_issue;
         if (w_issue) begin
            r_prod   <= w_prod;
            r_pfirst <= (r_i == IW'(0));
            r_plast  <= w_last_i;
            r_pslot  <= r_slot;
         end
         if (r_pv) begin
            r_acc <= w_acc_sum;
            if (r_plast) r_out[r_pslot] <= w_res;
         end
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_busy    <= 1'b1;
                  r_n       <= '0;
                  r_o       <= '0;
                  r_i       <= '0;
                  r_slot    <= '0;
                  r_mac_end <= 1'b0;
                  for (int n = 0; n < N_NODES; n++) begin
                     r_adj[n] <= bus.adj_in[n*N_NODES +: N_NODES];
                     for (int f = 0; f < F_IN; f++) begin
                        r_x[n][f] <= bus.x_in[(n*F_IN+f)*XW +: XW];
                     end
                  end
                  for (int o = 0; o < F_OUT; o++) begin
                     for (int i = 0; i < F_IN; i++) begin
                        r_w[o][i] <= bus.w_in[(o*F_IN+i)*WW +: WW];
                     end
                  end
               end
            end
            S_AGGR: begin
               for (int f = 0; f < F_IN; f++) begin
                  r_aggr[r_n][f] <= w_aggr_row[f];
               end
               if (w_last_n) r_n <= '0;
               else          r_n <= r_n + 1'b1;
            end
            S_MAC: begin
               if (!r_mac_end) begin
                  if (w_last_i) begin
                     r_i    <= '0;
                     r_slot <= r_slot + 1'b1;
                     if (w_last_o) begin
                        r_o <= '0;
                        if (w_last_n) begin
                           r_n       <= '0;
                           r_mac_end <= 1'b1;
                        end else begin
                           r_n <= r_n + 1'b1;
                        end
                     end else begin
                        r_o <= r_o + 1'b1;
                     end
                  end else begin
                     r_i <= r_i + 1'b1;
                  end
               end
            end
            S_DONE:  r_busy <= 1'b0;
            default: r_busy <= 1'b0;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   for (genvar s = 0; s < NS; s++) begin : g_out
      assign bus.out_data[s*OW +: OW] = r_out[s];
   end
endmodule
